// File: rtl/microbio_defs.sv
// Shared microbio definitions: RAM geometry, arbiter state encoding and request payload.
package microbio_defs;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between loader/CPU requesters, the arbiter and the shared RAM.
interface mem_arbiter_if;
  import microbio_defs::*;

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, mem_addr, mem_we, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin select; a masked port is ineligible, ties go to the port != last.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic [1:0] exclude_mask,
  output logic       valid_c,
  output logic       winner_c
);

  logic elig0;
  logic elig1;

  always_comb begin
    elig0    = req0 & ~exclude_mask[0];
    elig1    = req1 & ~exclude_mask[1];
    valid_c  = elig0 | elig1;
    winner_c = (elig0 && elig1) ? ~last : elig1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between loader (0) and CPU (1).
module mem_arbiter
  import microbio_defs::*;
(
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;

  logic          pick_valid_c;
  logic          pick_winner_c;
  logic [1:0]    excl_c;
  mem_req_t      sel_c;

  // In DONE the port just served may not win again straight away.
  assign excl_c = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  rr_pick2 u_pick (
    .req0         (bus.req0),
    .req1         (bus.req1),
    .last         (last_q),
    .exclude_mask (excl_c),
    .valid_c      (pick_valid_c),
    .winner_c     (pick_winner_c)
  );

  always_comb begin
    sel_c = pick_winner_c ? '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1}
                          : '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    ack_d       = 2'b00;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          owner_d     = pick_winner_c;
          we_d        = sel_c.we;
          mem_addr_d  = sel_c.addr;
          mem_we_d    = sel_c.we;
          mem_wdata_d = sel_c.wdata;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ack_d   = owner_q ? 2'b10 : 2'b01;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d = owner_q;
        if (!we_q) rdata_d = bus.mem_rdata;
        if (pick_valid_c) begin
          owner_d     = pick_winner_c;
          we_d        = sel_c.we;
          mem_addr_d  = sel_c.addr;
          mem_we_d    = sel_c.we;
          mem_wdata_d = sel_c.wdata;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      ack_q       <= 2'b00;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  // RAM output only exists during DONE, so a read's data is forwarded in the ack cycle.
  assign bus.rdata     = (state_q == ST_DONE && !we_q) ? bus.mem_rdata : rdata_q;
  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read RAM model.
module tb_mem_arbiter;
  import microbio_defs::*;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic test_reset();
    logic [3*DW+AW+1:0] outs;
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req0 = 1'($urandom); bus.req1 = 1'($urandom);
      bus.we0 = 1'($urandom);  bus.we1 = 1'($urandom);
      bus.addr0 = AW'($urandom); bus.addr1 = AW'($urandom);
      bus.wdata0 = DW'($urandom); bus.wdata1 = DW'($urandom);
      tick();
      outs = {bus.ack0, bus.ack1, bus.mem_we, bus.busy, bus.rdata, bus.mem_addr,
              bus.mem_wdata, bus.mem_wdata & '0};
      n_cmp++;
      if (outs !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got %h expected 0", outs);
      end
    end
    idle_inputs();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_after_reset: busy/ack0/ack1=%b expected 000", {bus.busy, bus.ack0, bus.ack1});
      end
    end
  endtask

  // Both request on the same edge: loader first (last=1 after reset), CPU back-to-back.
  task automatic test_contention();
    logic [1:0] exp_ack;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 9'h010; bus.wdata0 = 12'h111;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 9'h020; bus.wdata1 = 12'h222;
    for (int t = 1; t <= 5; t++) begin
      tick();
      exp_ack = (t == 2) ? 2'b01 : (t == 4) ? 2'b10 : 2'b00;
      n_cmp++;
      if ({bus.ack1, bus.ack0} !== exp_ack) begin
        n_bad++;
        $display("FAIL contention_ack t=%0d: {ack1,ack0}=%b expected %b", t, {bus.ack1, bus.ack0}, exp_ack);
      end
      if (t == 1 || t == 3) begin
        n_cmp++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, (t == 1) ? 9'h010 : 9'h020, (t == 1) ? 12'h111 : 12'h222}) begin
          n_bad++;
          $display("FAIL contention_mem t=%0d: we=%b addr=%h wdata=%h", t, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (t == 5) begin
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_bad++;
          $display("FAIL contention_idle: busy=%b expected 0", bus.busy);
        end
      end
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
    end
  endtask

  // Continuous requests from both: acks alternate 0,1,0,1 every 2 cycles.
  task automatic test_fairness();
    logic [1:0]    exp_ack;
    logic [DW-1:0] exp_rd;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 9'h010;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 9'h020;
    for (int t = 1; t <= 16; t++) begin
      tick();
      exp_ack = (t % 2 == 0) ? (((t / 2) % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
      n_cmp++;
      if ({bus.ack1, bus.ack0} !== exp_ack) begin
        n_bad++;
        $display("FAIL fairness_ack t=%0d: {ack1,ack0}=%b expected %b", t, {bus.ack1, bus.ack0}, exp_ack);
      end
      if (exp_ack != 2'b00) begin
        exp_rd = (exp_ack == 2'b01) ? 12'h111 : 12'h222;
        n_cmp++;
        if (bus.rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL fairness_rdata t=%0d: rdata=%h expected %h", t, bus.rdata, exp_rd);
        end
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000) begin
      n_bad++;
      $display("FAIL fairness_end: busy/ack0/ack1=%b expected 000", {bus.busy, bus.ack0, bus.ack1});
    end
  endtask

  task automatic test_write_read();
    int we_cnt;
    we_cnt = 0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 9'h005; bus.wdata0 = 12'hA5C;
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (bus.mem_we === 1'b1) we_cnt++;
      if (t == 1) begin
        n_cmp++;
        if ({bus.busy, bus.ack0, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 9'h005, 12'hA5C}) begin
          n_bad++;
          $display("FAIL write_access: busy=%b ack0=%b addr=%h wdata=%h", bus.busy, bus.ack0, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (t == 2) begin
        n_cmp++;
        if ({bus.ack1, bus.ack0} !== 2'b01) begin
          n_bad++;
          $display("FAIL write_ack: {ack1,ack0}=%b expected 01", {bus.ack1, bus.ack0});
        end
        bus.req0 = 1'b0;
      end
      if (t == 3) begin
        n_cmp++;
        if ({bus.busy, bus.ack0} !== 2'b00) begin
          n_bad++;
          $display("FAIL write_idle: busy/ack0=%b expected 00", {bus.busy, bus.ack0});
        end
      end
    end
    n_cmp++;
    if (we_cnt != 1) begin
      n_bad++;
      $display("FAIL write_we_cycles: got %0d expected 1", we_cnt);
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 9'h005;
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (t == 1) begin
        n_cmp++;
        if ({bus.mem_we, bus.busy, bus.mem_addr} !== {1'b0, 1'b1, 9'h005}) begin
          n_bad++;
          $display("FAIL read_access: we=%b busy=%b addr=%h", bus.mem_we, bus.busy, bus.mem_addr);
        end
      end
      if (t == 2) begin
        n_cmp++;
        if ({bus.ack0, bus.rdata} !== {1'b1, 12'hA5C}) begin
          n_bad++;
          $display("FAIL read_ack: ack0=%b rdata=%h expected 1/a5c", bus.ack0, bus.rdata);
        end
        bus.req0 = 1'b0;
      end
      if (t == 3) begin
        n_cmp++;
        if ({bus.busy, bus.ack0, bus.rdata} !== {1'b0, 1'b0, 12'hA5C}) begin
          n_bad++;
          $display("FAIL read_hold: busy=%b ack0=%b rdata=%h expected 0/0/a5c", bus.busy, bus.ack0, bus.rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 9'h005;
    tick();
    n_cmp++;
    if ({bus.busy, bus.mem_addr} !== {1'b1, 9'h005}) begin
      n_bad++;
      $display("FAIL rst_mid_access: busy=%b addr=%h expected 1/005", bus.busy, bus.mem_addr);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ack0, bus.ack1, bus.mem_we, bus.busy, bus.rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_values: ack1=%b busy=%b rdata=%h addr=%h", bus.ack1, bus.busy, bus.rdata, bus.mem_addr);
    end
    tick();
    n_cmp++;
    if ({bus.ack1, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mid_no_ack: ack1/busy=%b expected 00", {bus.ack1, bus.busy});
    end
    rstn = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.ack1, bus.ack0, bus.rdata} !== {2'b10, 12'hA5C}) begin
      n_bad++;
      $display("FAIL rst_reissue: {ack1,ack0}=%b rdata=%h expected 10/a5c", {bus.ack1, bus.ack0}, bus.rdata);
    end
    bus.req1 = 1'b0;
    tick();
    n_cmp++;
    if ({bus.busy, bus.ack1} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_reissue_idle: busy/ack1=%b expected 00", {bus.busy, bus.ack1});
    end
  endtask

  task automatic test_early_drop();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 9'h020;
    tick();
    bus.req1 = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ack1, bus.ack0, bus.rdata} !== {2'b10, 12'h222}) begin
      n_bad++;
      $display("FAIL early_drop_ack: {ack1,ack0}=%b rdata=%h expected 10/222", {bus.ack1, bus.ack0}, bus.rdata);
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      n_cmp++;
      if ({bus.ack1, bus.busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL early_drop_idle: ack1/busy=%b expected 00", {bus.ack1, bus.busy});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    idle_inputs();
    test_reset();
    test_contention();
    test_fairness();
    test_write_read();
    test_reset_mid_access();
    test_early_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
